cdc_pulse_arbiter: RTL and testbench



---
 rtl/cdc_pulse_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cdc_pulse_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_pulse_arbiter.sv
// Round-robin scheduler sharing one pulse-synchronizer channel among N_REQ requesters.
// Optional handshake watchdog enabled by defining CDC_ARB_TIMEOUT_EN.
module cdc_pulse_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TAG_W   = 2,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ovf_clr,
  input  logic             chan_busy,
  output logic             chan_pulse,
  output logic [TAG_W-1:0] chan_tag,
  output logic             done,
  output logic             pending,
  output logic [N_REQ-1:0] ovf,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(N_REQ - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r [N_REQ];
  logic [TAG_W-1:0] ptr_r, sel_s, next_ptr_s;
  logic [N_REQ-1:0] nz_s, dec_s, ovf_set_s;
  logic             found_s, grant_s, release_s, expire_s, wd_hit_s;
  int               rr_idx_s;

  assign pending    = |nz_s;
  assign next_ptr_s = (chan_tag == LAST_TAG) ? {TAG_W{1'b0}} : chan_tag + TAG_W'(1);

  // per-requester non-zero, decrement and overflow-set terms
  always_comb begin
    nz_s      = {N_REQ{1'b0}};
    dec_s     = {N_REQ{1'b0}};
    ovf_set_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      nz_s[i]      = (cnt_r[i] != {CNT_W{1'b0}});
      dec_s[i]     = grant_s && (sel_s == TAG_W'(i));
      ovf_set_s[i] = req[i] && !dec_s[i] && (cnt_r[i] == CNT_MAX);
    end
  end

  // first non-empty requester at or after the pointer, wrapping
  always_comb begin
    found_s  = 1'b0;
    sel_s    = {TAG_W{1'b0}};
    rr_idx_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx_s = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && nz_s[rr_idx_s]) begin
        found_s = 1'b1;
        sel_s   = TAG_W'(rr_idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // handshake sequencing; in WAIT_BUSY the watchdog wins so the wait can never overrun it
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    release_s = 1'b0;
    expire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wd_hit_s) begin
          expire_s = 1'b1;
          state_s  = IDLE;
        end else if (chan_busy) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!chan_busy) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else if (wd_hit_s) begin
          expire_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state register, latched tag, round-robin pointer and channel strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {TAG_W{1'b0}};
      chan_tag   <= {TAG_W{1'b0}};
      chan_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      chan_pulse <= grant_s;
      done       <= release_s;
      if (grant_s) begin
        chan_tag <= sel_s;
      end
      if (release_s || expire_s) begin
        ptr_r <= next_ptr_s;
      end
    end
  end

  // saturating pending counters; a set and a clear of ovf together resolve to set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      ovf <= {N_REQ{1'b0}};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && !dec_s[i]) begin
          if (cnt_r[i] != CNT_MAX) begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
        end else if (!req[i] && dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end
      end
      ovf <= (ovf & ~{N_REQ{ovf_clr}}) | ovf_set_s;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_r;
  logic            in_wait_s;

  assign in_wait_s = (state_r == WAIT_BUSY) || (state_r == WAIT_DONE);
  assign wd_hit_s  = in_wait_s && (wd_r == WD_W'(TIMEOUT - 1));

  // watchdog count across both wait states and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r        <= {WD_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      wd_r        <= (in_wait_s && (state_s != IDLE)) ? wd_r + WD_W'(1) : {WD_W{1'b0}};
      timeout_err <= (timeout_err && !ovf_clr) || expire_s;
    end
  end
`else
  assign wd_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Scoreboard bench for cdc_pulse_arbiter: expected tags are queued at stimulus time
// and popped by a channel responder that also models the synchronizer busy handshake.
module tb_cdc_pulse_arbiter;

  logic       clk, rst, ovf_clr, chan_busy;
  logic [3:0] req;
  logic       chan_pulse, done, pending, timeout_err;
  logic [1:0] chan_tag, exp_t;
  logic [3:0] ovf;

  logic [1:0] exp_tags[$];
  int         n_checks, n_fail, busy_len;
  bit         stall, no_ack, skip_done, active;

  cdc_pulse_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ovf_clr    (ovf_clr),
    .chan_busy  (chan_busy),
    .chan_pulse (chan_pulse),
    .chan_tag   (chan_tag),
    .done       (done),
    .pending    (pending),
    .ovf        (ovf),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req = v;
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((exp_tags.size() != 0 || active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val("quiet", 32'(exp_tags.size() == 0 && !active), 32'd1);
  endtask

  // channel responder: checks each pulse against the scoreboard and plays the busy handshake
  initial begin
    chan_busy = 1'b0;
    active    = 1'b0;
    forever begin
      @(negedge clk);
      if (chan_pulse === 1'b1) begin
        if (exp_tags.size() == 0) begin
          exp_t = 2'd0;
          check_val("spurious_pulse", 32'd1, 32'd0);
        end else begin
          exp_t = exp_tags.pop_front();
          check_val("pulse_tag", 32'(chan_tag), 32'(exp_t));
        end
        if (!no_ack) begin
          active = 1'b1;
          @(posedge clk);
          #1 chan_busy = 1'b1;
          @(negedge clk);
          check_val("pulse_width", 32'(chan_pulse), 32'd0);
          repeat (busy_len) @(posedge clk);
          while (stall) @(posedge clk);
          #1 chan_busy = 1'b0;
          @(negedge clk);
          if (!skip_done) begin
            check_val("done_early", 32'(done), 32'd0);
            @(negedge clk);
            check_val("done", 32'(done), 32'd1);
            check_val("tag_at_done", 32'(chan_tag), 32'(exp_t));
          end
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    ovf_clr   = 1'b0;
    stall     = 1'b0;
    no_ack    = 1'b0;
    skip_done = 1'b0;
    busy_len  = 6;
    repeat (2) @(negedge clk);
    check_val("rst_pulse", 32'(chan_pulse), 32'd0);
    check_val("rst_tag", 32'(chan_tag), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single event with a 6-cycle busy window
    exp_tags.push_back(2'd0);
    pulse_req(4'b0001);
    check_val("single_pending", 32'(pending), 32'd1);
    @(negedge clk);
    check_val("single_latency", 32'(chan_pulse), 32'd1);
    wait_quiet(200);
    check_val("single_pending_end", 32'(pending), 32'd0);

    // simultaneous requests from pointer 1 -> 1,2,3,0
    exp_tags.push_back(2'd1);
    exp_tags.push_back(2'd2);
    exp_tags.push_back(2'd3);
    exp_tags.push_back(2'd0);
    pulse_req(4'b1111);
    wait_quiet(400);

    // pointer back to 0: service 0, then 1001 must go 3 before 0
    exp_tags.push_back(2'd0);
    pulse_req(4'b0001);
    wait_quiet(200);
    exp_tags.push_back(2'd3);
    exp_tags.push_back(2'd0);
    pulse_req(4'b1001);
    wait_quiet(300);

    // five strobes for requester 2 inside one busy window (pointer now 1)
    busy_len = 16;
    exp_tags.push_back(2'd1);
    pulse_req(4'b0010);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      exp_tags.push_back(2'd2);
      pulse_req(4'b0100);
    end
    check_val("burst_pending", 32'(pending), 32'd1);
    busy_len = 4;
    wait_quiet(600);
    check_val("burst_ovf", 32'(ovf), 32'd0);

    // saturation: 9 strobes for requester 1 while the channel is stalled
    exp_tags.push_back(2'd3);
    pulse_req(4'b1000);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      pulse_req(4'b0010);
    end
    check_val("sat_ovf", 32'(ovf), 32'h2);
    check_val("sat_pending", 32'(pending), 32'd1);
    for (int k = 0; k < 7; k++) begin
      exp_tags.push_back(2'd1);
    end
    stall = 1'b0;
    wait_quiet(800);
    repeat (10) @(negedge clk);
    check_val("sat_ovf_sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("sat_ovf_clr", 32'(ovf), 32'd0);

    // reset while in WAIT_DONE with another event queued (pointer now 2)
    stall = 1'b1;
    exp_tags.push_back(2'd2);
    pulse_req(4'b0100);
    pulse_req(4'b1000);
    repeat (2) @(negedge clk);
    check_val("pre_rst_tag", 32'(chan_tag), 32'd2);
    rst = 1'b1;
    #1;
    check_val("mid_rst_pulse", 32'(chan_pulse), 32'd0);
    check_val("mid_rst_tag", 32'(chan_tag), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_pending", 32'(pending), 32'd0);
    check_val("mid_rst_ovf", 32'(ovf), 32'd0);
    skip_done = 1'b1;
    stall     = 1'b0;
    repeat (4) @(negedge clk);
    skip_done = 1'b0;
    exp_tags.delete();
    rst = 1'b0;
    @(negedge clk);
    exp_tags.push_back(2'd0);
    exp_tags.push_back(2'd1);
    exp_tags.push_back(2'd3);
    pulse_req(4'b1011);
    wait_quiet(400);

`ifdef CDC_ARB_TIMEOUT_EN
    // no busy response: watchdog expires 64 cycles after entering WAIT_BUSY
    no_ack = 1'b1;
    exp_tags.push_back(2'd0);
    pulse_req(4'b0001);
    repeat (65) @(negedge clk);
    check_val("wd_err_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check_val("wd_err", 32'(timeout_err), 32'd1);
    check_val("wd_no_done", 32'(done), 32'd0);
    no_ack = 1'b0;
    exp_tags.push_back(2'd1);
    pulse_req(4'b0010);
    wait_quiet(200);
    check_val("wd_err_sticky", 32'(timeout_err), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("wd_err_clr", 32'(timeout_err), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
